// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO pop port plus valid/ready output stream of the read drain stage.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  fifo_empty_i;
    logic [DATA_WIDTH-1:0] fifo_rdata_i;
    logic                  fifo_rdEn_o;
    logic                  m_valid_o;
    logic                  m_ready_i;
    logic [DATA_WIDTH-1:0] m_data_o;
    modport master (
        input  fifo_empty_i, fifo_rdata_i, m_ready_i,
        output fifo_rdEn_o, m_valid_o, m_data_o
    );
    modport slave (
        output fifo_empty_i, fifo_rdata_i, m_ready_i,
        input  fifo_rdEn_o, m_valid_o, m_data_o
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the dual-clock FIFO into a valid/ready stream via a 2-entry skid buffer.
// Optional statistics counters are enabled with `define RD_STATS_EN.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8
`ifdef RD_STATS_EN
    , parameter int CNT_WIDTH = 16
`endif
) (
    input  logic             rd_clk,
    input  logic             rst_n,
    input  logic             flush_i,
    fifo_rd_stream_if.master bus,
    output logic [1:0]       occ_o
`ifdef RD_STATS_EN
    , output logic [CNT_WIDTH-1:0] pop_cnt_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
`endif
);
    logic                  inflight;
    logic                  xfer;
    logic [1:0]            credit;
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;
    assign bus.m_valid_o = occ_o != 2'd0;
    assign bus.m_data_o  = buf0;
    assign xfer          = bus.m_valid_o & bus.m_ready_i;
    // Words held or arriving after this cycle's transfer; doubles as next occupancy.
    assign credit          = occ_o + {1'b0, inflight} - {1'b0, xfer};
    assign bus.fifo_rdEn_o = rst_n & !bus.fifo_empty_i & !flush_i & !credit[1];
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_o    <= 2'd0;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            inflight <= bus.fifo_rdEn_o;
            if (flush_i) begin
                occ_o <= 2'd0;
            end else begin
                occ_o <= credit;
                if (xfer)
                    buf0 <= (occ_o == 2'd2) ? buf1 : bus.fifo_rdata_i;
                else if (inflight && occ_o == 2'd0)
                    buf0 <= bus.fifo_rdata_i;
                // The second slot only matters at occupancy 2, so it may always take the arriving word.
                if (inflight)
                    buf1 <= bus.fifo_rdata_i;
            end
        end
    end
`ifdef RD_STATS_EN
    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_cnt_o   <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (bus.fifo_rdEn_o && !(&pop_cnt_o))
                pop_cnt_o <= pop_cnt_o + ONE;
            if (bus.m_valid_o && !bus.m_ready_i && !(&stall_cnt_o))
                stall_cnt_o <= stall_cnt_o + ONE;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed vector bench with a FIFO model and output stream monitor.
module tb_fifo_rd_stream;
    localparam int DW = 8;
    typedef struct {
        logic       rdy;
        logic       rden;
        logic       vld;
        logic [7:0] data;
        logic [1:0] occ;
    } vec_t;
    logic rd_clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_i = 1'b0;
    logic [1:0] occ_o;
`ifdef RD_STATS_EN
    logic [3:0] pop_cnt_o;
    logic [3:0] stall_cnt_o;
`endif
    logic [7:0] q[$];
    logic [7:0] got[$];
    logic rand_empty = 1'b0;
    int pops = 0;
    int n_chk = 0;
    int n_fail = 0;
    fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();
    fifo_rd_stream #(
        .DATA_WIDTH(DW)
`ifdef RD_STATS_EN
        , .CNT_WIDTH(4)
`endif
    ) dut (
        .rd_clk(rd_clk),
        .rst_n(rst_n),
        .flush_i(flush_i),
        .bus(bus.master),
        .occ_o(occ_o)
`ifdef RD_STATS_EN
        , .pop_cnt_o(pop_cnt_o),
        .stall_cnt_o(stall_cnt_o)
`endif
    );
    always #5 rd_clk = ~rd_clk;
    // FIFO with 1-cycle registered read latency, plus a monitor of accepted words.
    always @(posedge rd_clk) begin
        if (bus.fifo_rdEn_o) begin
            bus.fifo_rdata_i <= (q.size() != 0) ? q.pop_front() : 8'hEE;
            pops++;
        end
        if (bus.m_valid_o && bus.m_ready_i && !flush_i)
            got.push_back(bus.m_data_o);
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic cyc(input logic rdy, input logic fl);
        @(negedge rd_clk);
        rst_n = 1'b1;
        bus.m_ready_i = rdy;
        flush_i = fl;
        bus.fifo_empty_i = (q.size() == 0) | rand_empty;
        #1;
    endtask
    initial begin
        vec_t tv[6];
        int nxt;
        int viol;
        int bad;
        tv[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
        tv[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
        tv[2] = '{1'b1, 1'b1, 1'b1, 8'h11, 2'd1};
        tv[3] = '{1'b1, 1'b0, 1'b1, 8'h22, 2'd1};
        tv[4] = '{1'b1, 1'b0, 1'b1, 8'h33, 2'd1};
        tv[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
        bus.fifo_rdata_i = 8'h00;
        bus.m_ready_i = 1'b1;
        bus.fifo_empty_i = 1'b1;
        q = '{8'h11, 8'h22, 8'h33};
        repeat (2) @(negedge rd_clk);
        bus.fifo_empty_i = 1'b0;
        #1;
        chk("rst_rden", bus.fifo_rdEn_o, 1'b0);
        chk("rst_valid", bus.m_valid_o, 1'b0);
        chk("rst_occ", occ_o, 2'd0);
        chk("rst_data", bus.m_data_o, 8'h00);
        for (int i = 0; i < 6; i++) begin
            cyc(tv[i].rdy, 1'b0);
            chk($sformatf("lat%0d_rden", i), bus.fifo_rdEn_o, tv[i].rden);
            chk($sformatf("lat%0d_valid", i), bus.m_valid_o, tv[i].vld);
            chk($sformatf("lat%0d_occ", i), occ_o, tv[i].occ);
            if (tv[i].vld)
                chk($sformatf("lat%0d_data", i), bus.m_data_o, tv[i].data);
        end
        chk("lat_count", got.size(), 3);
        got.delete();
        pops = 0;
        q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0);
            if (i >= 2)
                chk($sformatf("bp_hold%0d", i), bus.m_data_o, 8'hA1);
        end
        chk("bp_pops", pops, 2);
        chk("bp_occ", occ_o, 2'd2);
        chk("bp_valid", bus.m_valid_o, 1'b1);
        chk("bp_rden", bus.fifo_rdEn_o, 1'b0);
        for (int i = 0; i < 20 && got.size() < 5; i++)
            cyc(1'b1, 1'b0);
        chk("bp_count", got.size(), 5);
        bad = 0;
        foreach (got[k])
            if (got[k] !== 8'hA1 + 8'(k)) bad++;
        chk("bp_order", bad, 0);
        got.delete();
        nxt = 0;
        viol = 0;
        for (int i = 0; i < 1000; i++) begin
            if (q.size() < 3) begin
                q.push_back(8'(nxt));
                nxt++;
            end
            rand_empty = ($urandom_range(0, 1) == 1);
            cyc($urandom_range(0, 1) == 1, 1'b0);
            if (bus.fifo_empty_i && bus.fifo_rdEn_o) viol++;
        end
        rand_empty = 1'b0;
        for (int i = 0; i < 50 && got.size() < nxt; i++)
            cyc(1'b1, 1'b0);
        chk("guard_violations", viol, 0);
        chk("guard_count", got.size(), nxt);
        bad = 0;
        foreach (got[k])
            if (got[k] !== 8'(k)) bad++;
        chk("guard_order", bad, 0);
        got.delete();
        q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk("fl_pre_occ", occ_o, 2'd1);
        chk("fl_rden", bus.fifo_rdEn_o, 1'b0);
        cyc(1'b0, 1'b0);
        chk("fl_valid", bus.m_valid_o, 1'b0);
        chk("fl_occ", occ_o, 2'd0);
        chk("fl_resume", bus.fifo_rdEn_o, 1'b1);
        for (int i = 0; i < 20 && got.size() < 2; i++)
            cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b1, 1'b0);
        chk("fl_count", got.size(), 2);
        chk("fl_word0", (got.size() > 0) ? got[0] : 8'h00, 8'hB3);
        chk("fl_word1", (got.size() > 1) ? got[1] : 8'h00, 8'hB4);
`ifdef RD_STATS_EN
        @(negedge rd_clk);
        rst_n = 1'b0;
        #1;
        chk("st_rst_pop", pop_cnt_o, 4'd0);
        chk("st_rst_stall", stall_cnt_o, 4'd0);
        for (int i = 0; i < 20; i++)
            q.push_back(8'(i));
        for (int i = 0; i < 40; i++)
            cyc(!(i >= 5 && i < 8), 1'b0);
        chk("st_pop", pop_cnt_o, 4'd15);
        chk("st_stall", stall_cnt_o, 4'd3);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
